// File: rtl/picoview_pkg.sv
// Shared definitions for the picoview ETS front end.
// State codes, defaults and control-register bit positions.
package picoview_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SETTLE = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_EMIT   = 3'd4;
  localparam logic [2:0] ST_STEP   = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_SETTLE = ST_SETTLE,
    S_RUN    = ST_RUN,
    S_WAIT   = ST_WAIT,
    S_EMIT   = ST_EMIT,
    S_STEP   = ST_STEP
  } sweep_state_t;

  localparam int DEF_SETTLE_CYCLES = 64;
  localparam int DEF_TIMEOUT_WIDTH = 24;

  localparam int CTRL_SWEEP_START_BIT = 8;
  localparam int CTRL_SWEEP_ABORT_BIT = 9;

endpackage

// File: rtl/ets_sweep_timer.sv
// Loadable up-counter with clear, enable and terminal compare.
// hit is high while the count equals limit.
module ets_sweep_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         hit
);

  logic [W-1:0] count;

  // clear beats load beats count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign hit = (count == limit);

endmodule

// File: rtl/ets_sweep_sequencer.sv
// Equivalent-time sampling sweep sequencer.
// Settle, run, wait, emit and step for each phase position.
module ets_sweep_sequencer
  import picoview_pkg::*;
#(
  parameter int RESULT_WIDTH  = 32,
  parameter int STEP_WIDTH    = 16,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_WIDTH = DEF_TIMEOUT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [STEP_WIDTH-1:0]    num_steps,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_limit,
  input  logic                     locked,
  input  logic                     result_ready,
  input  logic [RESULT_WIDTH-1:0]  result,
  output logic                     phase_step,
  output logic                     request_run,
  output logic                     sample_valid,
  output logic [RESULT_WIDTH-1:0]  sample_data,
  output logic [STEP_WIDTH-1:0]    sample_index,
  input  logic                     sample_ready,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  localparam int SCW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [SCW-1:0] SETTLE_LAST =
    SCW'(SETTLE_CYCLES - 1);

  sweep_state_t state, next;

  logic [STEP_WIDTH-1:0]    steps_q;
  logic [STEP_WIDTH-1:0]    index;
  logic [TIMEOUT_WIDTH-1:0] tl_q;

  logic settle_hit;
  logic to_hit;
  logic last;

  logic accept;
  logic capture;
  logic advance;
  logic done_set;
  logic err_set;

  assign last = (index == steps_q - 1'b1);

  ets_sweep_timer #(.W(SCW)) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      ((state != S_SETTLE) || !locked),
    .load       (1'b0),
    .load_value ('0),
    .enable     ((state == S_SETTLE) && locked),
    .limit      (SETTLE_LAST),
    .hit        (settle_hit)
  );

  ets_sweep_timer #(.W(TIMEOUT_WIDTH)) u_timeout (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state != S_WAIT),
    .load       (1'b0),
    .load_value ('0),
    .enable     ((state == S_WAIT) && !result_ready),
    .limit      (tl_q - 1'b1),
    .hit        (to_hit)
  );

  // next state and one-cycle actions; abort overrides all
  always_comb begin
    next     = state;
    accept   = 1'b0;
    capture  = 1'b0;
    advance  = 1'b0;
    done_set = 1'b0;
    err_set  = 1'b0;
    if (state == S_IDLE) begin
      if (start && !abort) begin
        if (num_steps == '0) begin
          done_set = 1'b1;
        end else begin
          accept = 1'b1;
          next   = S_SETTLE;
        end
      end
    end else if (abort) begin
      next = S_IDLE;
    end else begin
      unique case (state)
        S_SETTLE: begin
          if (locked && settle_hit) next = S_RUN;
        end
        S_RUN: next = S_WAIT;
        S_WAIT: begin
          if (result_ready) begin
            capture = 1'b1;
            next    = S_EMIT;
          end else if (tl_q != '0 && to_hit) begin
            err_set  = 1'b1;
            done_set = 1'b1;
            next     = S_IDLE;
          end
        end
        S_EMIT: begin
          if (sample_ready) begin
            if (last) begin
              done_set = 1'b1;
              next     = S_IDLE;
            end else begin
              advance = 1'b1;
              next    = S_STEP;
            end
          end
        end
        S_STEP: next = S_SETTLE;
        default: next = S_IDLE;
      endcase
    end
  end

  // state plus registered outputs decoded from next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      busy         <= 1'b0;
      request_run  <= 1'b0;
      phase_step   <= 1'b0;
      sample_valid <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= next;
      busy         <= (next != S_IDLE);
      request_run  <= (next == S_RUN);
      phase_step   <= (next == S_STEP);
      sample_valid <= (next == S_EMIT);
      done         <= done_set;
    end
  end

  // sweep parameters, index, capture and sticky error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      steps_q      <= '0;
      tl_q         <= '0;
      index        <= '0;
      error        <= 1'b0;
      sample_data  <= '0;
      sample_index <= '0;
    end else begin
      if (accept) begin
        steps_q <= num_steps;
        tl_q    <= timeout_limit;
        index   <= '0;
        error   <= 1'b0;
      end
      if (err_set) error <= 1'b1;
      if (capture) begin
        sample_data  <= result;
        sample_index <= index;
      end
      if (advance) index <= index + 1'b1;
    end
  end

endmodule

// File: tb/tb_ets_sweep_sequencer.sv
// Self-checking bench for ets_sweep_sequencer.
// Directed timing cases plus randomized sweeps against a transaction model.
module tb_ets_sweep_sequencer;

  localparam int RW = 32;
  localparam int SW = 4;
  localparam int SC = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [SW-1:0] num_steps = '0;
  logic [TW-1:0] timeout_limit = '0;
  logic          locked = 1'b1;
  logic          result_ready = 1'b0;
  logic [RW-1:0] result = '0;
  logic          sample_ready = 1'b1;
  logic          phase_step;
  logic          request_run;
  logic          sample_valid;
  logic [RW-1:0] sample_data;
  logic [SW-1:0] sample_index;
  logic          busy;
  logic          done;
  logic          error;

  ets_sweep_sequencer #(
    .RESULT_WIDTH  (RW),
    .STEP_WIDTH    (SW),
    .SETTLE_CYCLES (SC),
    .TIMEOUT_WIDTH (TW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .abort         (abort),
    .num_steps     (num_steps),
    .timeout_limit (timeout_limit),
    .locked        (locked),
    .result_ready  (result_ready),
    .result        (result),
    .phase_step    (phase_step),
    .request_run   (request_run),
    .sample_valid  (sample_valid),
    .sample_data   (sample_data),
    .sample_index  (sample_index),
    .sample_ready  (sample_ready),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_start = 0;

  bit   resp_en = 1'b1;
  bit   resp_fixed = 1'b0;
  int   resp_delay = 5;
  bit   rdy_rand = 1'b0;
  bit   lock_rand = 1'b0;
  logic rdy_val = 1'b1;
  logic lock_val = 1'b1;

  int            req_q[$];
  int            ps_q[$];
  int            done_q[$];
  bit            derr_q[$];
  bit            dbusy_q[$];
  int            xc_q[$];
  logic [SW-1:0] xi_q[$];
  logic [RW-1:0] xd_q[$];
  logic [RW-1:0] sent_q[$];
  int            nvalid = 0;

  bit            hold_prev = 1'b0;
  logic [RW-1:0] hold_d = '0;
  logic [SW-1:0] hold_i = '0;

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // input drivers settle 2 time units after the edge
  always @(posedge clk) begin
    #2;
    sample_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_val;
    locked = lock_rand ? ($urandom_range(0, 9) != 0) : lock_val;
  end

  // sampler model: answers each run after resp_delay cycles
  always begin : responder
    logic [RW-1:0] d;
    int k;
    k = 0;
    forever begin
      @(negedge clk);
      if (rst_n && request_run && resp_en) begin
        d = resp_fixed ? RW'(32'hA0 + k) : RW'($urandom);
        k++;
        repeat (resp_delay) @(posedge clk);
        #1;
        result = d;
        result_ready = 1'b1;
        sent_q.push_back(d);
        @(posedge clk);
        #1;
        result_ready = 1'b0;
      end
      if (!resp_fixed) k = 0;
    end
  end

  // event recorder and stream-hold rule
  always @(negedge clk) begin
    if (hold_prev && rst_n) begin
      check("hold_valid", 64'(sample_valid), 64'd1);
      check("hold_data", 64'(sample_data), 64'(hold_d));
      check("hold_index", 64'(sample_index), 64'(hold_i));
    end
    hold_prev = rst_n && sample_valid && !sample_ready && !abort;
    hold_d = sample_data;
    hold_i = sample_index;
    if (rst_n) begin
      if (request_run) req_q.push_back(cyc);
      if (phase_step) ps_q.push_back(cyc);
      if (done) begin
        done_q.push_back(cyc);
        derr_q.push_back(error);
        dbusy_q.push_back(busy);
      end
      if (sample_valid) nvalid++;
      if (sample_valid && sample_ready) begin
        xc_q.push_back(cyc);
        xi_q.push_back(sample_index);
        xd_q.push_back(sample_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(int n, int tl);
    tick();
    num_steps = SW'(n);
    timeout_limit = TW'(tl);
    start = 1'b1;
    t_start = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(int d0, int budget);
    int k;
    k = 0;
    while (done_q.size() <= d0 && k < budget) begin
      tick();
      k++;
    end
    check("done_seen", 64'(done_q.size() > d0), 64'd1);
  endtask

  task automatic wait_req(int r0, int budget);
    int k;
    k = 0;
    while (req_q.size() <= r0 && k < budget) begin
      tick();
      k++;
    end
    check("req_seen", 64'(req_q.size() > r0), 64'd1);
  endtask

  task automatic check_outs_zero(string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_run"}, 64'(request_run), 64'd0);
    check({tag, "_step"}, 64'(phase_step), 64'd0);
    check({tag, "_valid"}, 64'(sample_valid), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_data"}, 64'(sample_data), 64'd0);
    check({tag, "_index"}, 64'(sample_index), 64'd0);
  endtask

  // a clean sweep of n steps: n transfers in order, n runs,
  // n-1 phase steps, one done with error low and busy low
  task automatic check_sweep(string tag, int n, int x0, int s0,
                             int p0, int r0, int d0);
    repeat (3) tick();
    check({tag, "_xfers"}, 64'(xc_q.size() - x0), 64'(n));
    check({tag, "_runs"}, 64'(req_q.size() - r0), 64'(n));
    check({tag, "_steps"}, 64'(ps_q.size() - p0), 64'(n - 1));
    check({tag, "_dones"}, 64'(done_q.size() - d0), 64'd1);
    if (done_q.size() > d0) begin
      check({tag, "_err"}, 64'(derr_q[d0]), 64'd0);
      check({tag, "_busy"}, 64'(dbusy_q[d0]), 64'd0);
    end
    for (int i = 0; i < n; i++) begin
      if (x0 + i < xi_q.size()) begin
        check({tag, "_idx"}, 64'(xi_q[x0 + i]), 64'(i));
        if (s0 + i < sent_q.size())
          check({tag, "_dat"}, 64'(xd_q[x0 + i]),
                64'(sent_q[s0 + i]));
      end
    end
  endtask

  initial begin : main
    int x0, s0, p0, r0, d0, v0, n, lc;

    repeat (3) tick();
    check_outs_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick();

    // basic three-step sweep with timing
    resp_fixed = 1'b1;
    resp_delay = 5;
    x0 = xc_q.size(); s0 = sent_q.size(); p0 = ps_q.size();
    r0 = req_q.size(); d0 = done_q.size();
    go(3, 0);
    check("busy_t1", 64'(busy), 64'd1);
    wait_done(d0, 200);
    check_sweep("basic", 3, x0, s0, p0, r0, d0);
    if (xc_q.size() >= x0 + 3 && req_q.size() >= r0 + 2 &&
        ps_q.size() > p0 && done_q.size() > d0) begin
      check("run0_at", 64'(req_q[r0]), 64'(t_start + 1 + SC));
      check("xfer0_at", 64'(xc_q[x0]), 64'(req_q[r0] + 6));
      check("step0_at", 64'(ps_q[p0]), 64'(xc_q[x0] + 1));
      check("run1_at", 64'(req_q[r0 + 1]),
            64'(xc_q[x0] + 2 + SC));
      check("done_at", 64'(done_q[d0]), 64'(xc_q[x0 + 2] + 1));
      for (int i = 0; i < 3; i++)
        check("basic_val", 64'(xd_q[x0 + i]), 64'(32'hA0 + i));
    end else begin
      check("basic_events", 64'd0, 64'd1);
    end
    resp_fixed = 1'b0;

    // lock lost for two cycles in SETTLE
    r0 = req_q.size(); d0 = done_q.size();
    go(1, 0);
    tick();
    lock_val = 1'b0;
    tick();
    tick();
    lock_val = 1'b1;
    lc = cyc;
    wait_done(d0, 200);
    if (req_q.size() > r0)
      check("relock_run", 64'(req_q[r0]), 64'(lc + SC));

    // timeout with the sampler silent, then restart clears error
    resp_en = 1'b0;
    r0 = req_q.size(); d0 = done_q.size();
    go(2, 10);
    wait_done(d0, 200);
    check("to_runs", 64'(req_q.size() - r0), 64'd1);
    if (done_q.size() > d0 && req_q.size() > r0) begin
      check("to_at", 64'(done_q[d0]), 64'(req_q[r0] + 11));
      check("to_err", 64'(derr_q[d0]), 64'd1);
      check("to_busy", 64'(dbusy_q[d0]), 64'd0);
    end
    check("err_sticky", 64'(error), 64'd1);
    resp_en = 1'b1;
    resp_delay = 3;
    x0 = xc_q.size(); s0 = sent_q.size(); p0 = ps_q.size();
    r0 = req_q.size(); d0 = done_q.size();
    go(1, 10);
    check("err_clr", 64'(error), 64'd0);
    wait_done(d0, 200);
    check_sweep("after_to", 1, x0, s0, p0, r0, d0);

    // downstream stall in EMIT
    rdy_val = 1'b0;
    x0 = xc_q.size(); s0 = sent_q.size(); p0 = ps_q.size();
    r0 = req_q.size(); d0 = done_q.size();
    go(2, 0);
    lc = 0;
    while (!sample_valid && lc < 100) begin
      tick();
      lc++;
    end
    check("stall_valid", 64'(sample_valid), 64'd1);
    repeat (20) tick();
    check("stall_nostep", 64'(ps_q.size() - p0), 64'd0);
    check("stall_noxfer", 64'(xc_q.size() - x0), 64'd0);
    rdy_val = 1'b1;
    wait_done(d0, 200);
    check_sweep("stall", 2, x0, s0, p0, r0, d0);

    // abort in WAIT, late result must be ignored
    resp_delay = 8;
    x0 = xc_q.size(); r0 = req_q.size();
    d0 = done_q.size(); v0 = nvalid;
    go(2, 0);
    wait_req(r0, 100);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (15) tick();
    check("ab_done", 64'(done_q.size() - d0), 64'd0);
    check("ab_valid", 64'(nvalid - v0), 64'd0);
    check("ab_xfer", 64'(xc_q.size() - x0), 64'd0);
    check("ab_busy", 64'(busy), 64'd0);
    check("ab_err", 64'(error), 64'd0);
    check("ab_runs", 64'(req_q.size() - r0), 64'd1);

    // zero-step request
    r0 = req_q.size(); d0 = done_q.size();
    go(0, 0);
    check("zero_done", 64'(done), 64'd1);
    check("zero_busy", 64'(busy), 64'd0);
    repeat (10) tick();
    check("zero_runs", 64'(req_q.size() - r0), 64'd0);
    check("zero_dones", 64'(done_q.size() - d0), 64'd1);
    if (done_q.size() > d0)
      check("zero_at", 64'(done_q[d0]), 64'(t_start + 1));

    // start and abort together in IDLE
    r0 = req_q.size();
    tick();
    num_steps = 3;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("sa_busy", 64'(busy), 64'd0);
    repeat (12) tick();
    check("sa_runs", 64'(req_q.size() - r0), 64'd0);

    // largest step count, index must not wrap
    resp_delay = 1;
    x0 = xc_q.size(); s0 = sent_q.size(); p0 = ps_q.size();
    r0 = req_q.size(); d0 = done_q.size();
    go((1 << SW) - 1, 0);
    wait_done(d0, 1000);
    check_sweep("max", (1 << SW) - 1, x0, s0, p0, r0, d0);

    // randomized sweeps under stall and lock noise
    rdy_rand = 1'b1;
    lock_rand = 1'b1;
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(1, 6);
      resp_delay = $urandom_range(1, 6);
      x0 = xc_q.size(); s0 = sent_q.size(); p0 = ps_q.size();
      r0 = req_q.size(); d0 = done_q.size();
      go(n, ($urandom_range(0, 1) == 0) ? 0 : 200);
      wait_done(d0, 3000);
      check_sweep("rand", n, x0, s0, p0, r0, d0);
    end
    rdy_rand = 1'b0;
    lock_rand = 1'b0;

    // reset in the middle of a sweep
    resp_delay = 20;
    go(2, 0);
    repeat (8) tick();
    check("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    tick();
    check_outs_zero("midrst");
    tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("post_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ets_sweep_sequencer.md
# ets_sweep_sequencer

Sequences a complete equivalent-time sampling sweep. For each of `num_steps` clock-phase positions, the block waits for the ETS clock generator to settle and lock, then triggers one offset-sampler run. It captures the result and hands it downstream over a valid/ready stream, and pulses a phase step before the next position. It sits between the SPI register bank and the clock generator/sampler pair, replacing per-step host pokes of the control register.

## Interface
Parameters:
- `RESULT_WIDTH`, 32: width of sampler result and `sample_data`.
- `STEP_WIDTH`, 16: width of step count and index.
- `SETTLE_CYCLES`, 64: consecutive locked cycles required before each run; must be ≥1.
- `TIMEOUT_WIDTH`, 24: width of the run timeout counter.

Ports:
- `clk` in 1: system clock (all logic in this single domain).
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle sweep request.
- `abort` in 1: one-cycle cancel.
- `num_steps` in STEP_WIDTH: phase positions per sweep; sampled when `start` is accepted.
- `timeout_limit` in TIMEOUT_WIDTH: maximum WAIT cycles; 0 disables the timeout. Sampled when `start` is accepted.
- `locked` in 1: clock generator lock.
- `result_ready` in 1: sampler one-cycle completion pulse.
- `result` in RESULT_WIDTH: sampler result, valid with `result_ready`.
- `phase_step` out 1: one-cycle phase-advance pulse to the clock generator.
- `request_run` out 1: one-cycle run request to the sampler.
- `sample_valid` out 1: downstream stream valid.
- `sample_data` out RESULT_WIDTH: captured result.
- `sample_index` out STEP_WIDTH: step number of `sample_data`.
- `sample_ready` in 1: downstream stream ready.
- `busy` out 1: sweep in progress (state ≠ IDLE).
- `done` out 1: one-cycle pulse when the sweep ends, normally or on timeout.
- `error` out 1: sticky timeout flag.

## Operation
- States: IDLE, SETTLE, RUN, WAIT, EMIT, STEP.
- IDLE, with `start` asserted:
  - `num_steps`=0: `done` pulses next cycle; no run is issued; the block stays in IDLE.
  - Otherwise: latch `num_steps` and `timeout_limit`, clear `error`, set index=0, go to SETTLE.
- SETTLE: the settle counter increments each cycle `locked`=1 and clears whenever `locked`=0. Exit to RUN when the counter reaches SETTLE_CYCLES-1 with `locked`=1.
- RUN: `request_run`=1 for exactly this one cycle; next state is WAIT; the timeout counter clears.
- WAIT:
  - On `result_ready`: capture `result` into `sample_data` and index into `sample_index`, then go to EMIT.
  - Otherwise the timeout counter increments. If `timeout_limit`≠0 and the counter reaches `timeout_limit`: set `error`=1, pulse `done`, go to IDLE.
  - `result_ready` outside WAIT is ignored.
- EMIT: `sample_valid`=1. `sample_data` and `sample_index` are held stable until the cycle in which `sample_valid`&&`sample_ready`. On that transfer:
  - If index = `num_steps`-1: pulse `done`, go to IDLE.
  - Otherwise increment index and go to STEP.
- STEP: `phase_step`=1 for one cycle, then SETTLE. Step 0 is sampled at the current phase, with no leading `phase_step`.
- `abort` in any non-IDLE state wins over every other event. Next state is IDLE; `done` is not pulsed; `error` is unchanged; a pending EMIT sample is dropped and `sample_valid` falls next cycle.
- `start` while `busy` is ignored. `start` and `abort` in the same IDLE cycle: `abort` wins and the sweep does not start.
- The index never wraps: `num_steps`=2^STEP_WIDTH-1 produces indices 0 … 2^STEP_WIDTH-2.
- Reset mid-sweep: immediate return to IDLE; all outputs take their reset values.

## Timing
- Reset values: state IDLE; `phase_step`, `request_run`, `sample_valid`, `busy`, `done` and `error` all 0; `sample_data` and `sample_index` 0.
- All outputs are registered; no combinational input-to-output path. The exception is `sample_ready`, which only affects the next state.
- `start` accepted at cycle T: `busy`=1 at T+1 (SETTLE). With `locked` held high, `request_run`=1 at T+1+SETTLE_CYCLES.
- `result_ready` at cycle R: `sample_valid`=1 at R+1.
- Transfer at cycle X, not last step: `phase_step`=1 at X+1; the next `request_run` follows at X+2+SETTLE_CYCLES.
- Transfer at cycle X, last step: `done`=1 and `busy`=0 at X+1.
- Timeout: `error` and `done` rise, and `busy` falls, one cycle after the counter hits the limit.

## Structure
- Shared package `picoview_pkg`:
  - state encoding localparams;
  - default SETTLE_CYCLES and TIMEOUT_WIDTH values;
  - control-register bit positions for the sweep start/abort bits.
- One sub-module, `ets_sweep_timer`: a loadable counter with clear, enable and terminal-compare. It is instantiated twice, once for settle and once for timeout.
- The FSM and the capture registers live in the top level.

## Test plan
- SETTLE_CYCLES=4, `num_steps`=3, `locked`=1, `sample_ready`=1, sampler answering 5 cycles after `request_run` with results 0xA0, 0xA1, 0xA2 → three transfers with indices 0, 1, 2 and matching data; exactly 2 `phase_step` pulses; exactly one `done`; `error`=0.
- `locked` dropped for 2 cycles mid-SETTLE → `request_run` is delayed until 4 consecutive locked cycles have elapsed after `locked` returns.
- `timeout_limit`=10, sampler never answers → `error`=1 and `done`=1 exactly 11 cycles after `request_run`; `busy`=0. A following `start` clears `error`.
- `sample_ready` held low for 20 cycles in EMIT → `sample_valid`, `sample_data` and `sample_index` stay constant; no `phase_step` occurs before the transfer.
- `abort` during WAIT, then a late `result_ready` → IDLE; no `done`; no `sample_valid`; the late result is ignored.
- `num_steps`=0 `start` → `done` pulses at T+1; no `request_run`; `busy` stays 0.
